nand_sweep_ctrl: RTL
====================

// Module: nand_sweep_ctrl
// PURPOSE
//   Sequencer that exercises an external 2-input gate (default: the NAND gate) in hardware.
//   It drives the gate inputs through vectors {a,b} = 00, 01, 10, 11.
//   It waits a programmable settle time, samples the gate output and compares it with an
//   expected truth table. It reports per-vector mismatches and a pass flag.
//   Sits beside the gate instance as its only driver; gate_y returns to this block.
// PARAMETERS
//   SETTLE_CYCLES  2        cycles each vector is held before sampling; legal range >= 1
//   EXPECT         4'b0111  expected y indexed by {a,b}; bit[3] = y for a=1,b=1 (NAND)
//   CNT_W          8        width of completed-sweep counter
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      1-cycle request to begin a sweep; ignored unless idle
//   abort      in   1      terminate an in-progress sweep
//   gate_y     in   1      output of the gate under control
//   gate_a     out  1      gate input a, registered
//   gate_b     out  1      gate input b, registered
//   busy       out  1      high from the cycle after start until done or abort
//   done       out  1      1-cycle pulse when a sweep completes
//   pass       out  1      1 = last completed sweep had zero mismatches
//   fail_mask  out  4      bit[{a,b}] set = mismatch at that vector
//   sweep_cnt  out  CNT_W  completed sweeps, saturating
// BEHAVIOUR
//   Reset (async): all outputs 0; state IDLE; vector index 0; settle counter 0.
//   States: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
//   IDLE: gate_a=gate_b=0, busy=0.
//     start=1 & abort=0 -> clear fail_mask, pass<=0, vec<=0, cnt<=0, go to SETTLE.
//   SETTLE: {gate_a,gate_b}=vec; cnt increments; when cnt==SETTLE_CYCLES-1 go to SAMPLE.
//   SAMPLE: if gate_y != EXPECT[vec], set fail_mask[vec].
//     vec==3 -> DONE; else vec++, cnt<=0, go to SETTLE.
//   DONE (1 cycle): done=1, busy=0; pass <= ~|fail_mask; sweep_cnt++ unless all-ones; -> IDLE.
//   Latency: done is high in cycle 4*(SETTLE_CYCLES+1)+1 after the start edge (13 for default).
//   Inputs are held constant for SETTLE_CYCLES+1 cycles per vector; sampling is in the last one.
//   abort while busy -> IDLE at the next edge.
//     No done pulse; pass<=0; fail_mask keeps its partial result; sweep_cnt is unchanged.
//   start and abort both high in IDLE -> abort wins; remain IDLE.
//   start while busy: ignored; no queuing.
//   start in the DONE cycle: ignored (the state is not IDLE).
//   rst mid-sweep: immediate return to reset values; gate inputs go to 0 asynchronously.
//   gate_y is treated as synchronous to clk; no synchronizer inside.
// STRUCTURE
//   Shared package gate_pkg: state encoding constants (IDLE, SETTLE, SAMPLE, DONE);
//     truth-table constants NAND_TT=4'b0111, AND_TT=4'b1000, OR_TT=4'b1110,
//     NOR_TT=4'b0001, XOR_TT=4'b0110.
//   Sub-module settle_timer: count up to SETTLE_CYCLES-1 with load/clear and an expire flag.
//   FSM, vector index, compare and status registers stay in nand_sweep_ctrl.
//   The bench instantiates nand_sweep_ctrl with the nand_gate and wires gate_a/gate_b/gate_y.
// TESTING
//   1 Nominal: NAND gate, SETTLE=2, start pulse ->
//     gate inputs 00,01,10,11, each held 3 cycles; done at cycle 13;
//     pass=1, fail_mask=0000, sweep_cnt=1.
//   2 Faults, each ->
//     gate_y stuck-at-1: done, pass=0, fail_mask=1000.
//     AND gate with EXPECT=NAND_TT: fail_mask=1111.
//     Same AND gate with EXPECT=AND_TT: pass=1.
//   3 Abort: abort during the SETTLE of vector 10 ->
//     busy=0 and gate_a=gate_b=0 next cycle; no done pulse; pass=0; sweep_cnt unchanged.
//   4 Simultaneous and ignored requests:
//     start+abort in IDLE -> stays IDLE, busy=0.
//     start pulse at cycle 5 of a sweep -> no effect; single done at cycle 13.
//   5 Reset mid-sweep: rst asserted between clock edges at cycle 7 ->
//     all outputs 0 before the next edge; a fresh start afterwards completes with pass=1.
//   6 Saturation: CNT_W=2, 5 back-to-back good sweeps -> sweep_cnt = 1,2,3,3,3.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared definitions for the gate sweep sequencer: FSM states and
// 2-input truth tables indexed by {a,b}.
package gate_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } sweep_state_t;

   localparam logic [3:0] NAND_TT = 4'b0111;
   localparam logic [3:0] AND_TT  = 4'b1000;
   localparam logic [3:0] OR_TT   = 4'b1110;
   localparam logic [3:0] NOR_TT  = 4'b0001;
   localparam logic [3:0] XOR_TT  = 4'b0110;

endpackage

// File: rtl/nand_sweep_ctrl_settle_timer.sv
// Settle timer: counts 0..SETTLE_CYCLES-1 while enabled; expire flags the
// last count and the counter wraps to 0 on the following enabled edge.
module settle_timer #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned   CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= expire ? '0 : cnt + 1'b1;
      end
   end

   assign expire = (cnt == LAST);

endmodule

// File: rtl/nand_sweep_ctrl.sv
// Sequencer that drives an external 2-input gate through 00,01,10,11,
// samples its output after a settle time and checks it against EXPECT.
module nand_sweep_ctrl
   import gate_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [3:0]  EXPECT        = NAND_TT,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             gate_y,
   output logic             gate_a,
   output logic             gate_b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [3:0]       fail_mask,
   output logic [CNT_W-1:0] sweep_cnt
);

   sweep_state_t state_q, state_d;
   logic [1:0]   vec_q, vec_d;
   logic         tmr_clr, tmr_en, tmr_expire;

   settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .expire(tmr_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = SETTLE;
               vec_d   = '0;
               tmr_clr = 1'b1;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_d = IDLE;
               tmr_clr = 1'b1;
            end else begin
               tmr_en = 1'b1;
               if (tmr_expire) state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            tmr_clr = 1'b1;
            if (abort) begin
               state_d = IDLE;
            end else if (vec_q == 2'd3) begin
               state_d = DONE;
            end else begin
               state_d = SETTLE;
               vec_d   = vec_q + 2'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == SETTLE) || (state_q == SAMPLE);
   assign done = (state_q == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_q     <= '0;
         gate_a    <= 1'b0;
         gate_b    <= 1'b0;
         pass      <= 1'b0;
         fail_mask <= '0;
         sweep_cnt <= '0;
      end else begin
         vec_q <= vec_d;
         // Gate inputs follow the next state so the vector is live for the
         // whole SETTLE+SAMPLE window and drops to 0 on the exit edge.
         {gate_a, gate_b} <= ((state_d == SETTLE) || (state_d == SAMPLE)) ? vec_d : 2'b00;
         case (state_q)
            IDLE: begin
               if (start && !abort) begin
                  fail_mask <= '0;
                  pass      <= 1'b0;
               end
            end
            SETTLE: begin
               if (abort) pass <= 1'b0;
            end
            SAMPLE: begin
               if (abort) pass <= 1'b0;
               else if (gate_y != EXPECT[vec_q]) fail_mask[vec_q] <= 1'b1;
            end
            DONE: begin
               pass <= ~|fail_mask;
               if (sweep_cnt != '1) sweep_cnt <= sweep_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
